// File: rtl/hero_write_rx_if.sv
// Bundle of hero write bus inputs and the downstream valid/ready FIFO side.
// The slave modport is the receiver; the master modport drives the bus and consumes entries.
interface hero_write_rx_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 36,
  parameter int SUB_W  = 7
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [1:0]        hero_cycle_type;
  logic [DATA_W-1:0] hero_wdat;
  logic [SUB_W-1:0]  hero_sub;
  logic              hero_clk_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_wdat;
  logic [SUB_W-1:0]  out_sub;
  logic              out_last;
  logic              out_err;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow_pulse;
  logic              proto_err_pulse;

  modport slave (
    input  hero_cycle_type, hero_wdat, hero_sub, hero_clk_en, out_ready,
    output out_valid, out_wdat, out_sub, out_last, out_err, fifo_level,
           overflow_pulse, proto_err_pulse
  );

  modport master (
    output hero_cycle_type, hero_wdat, hero_sub, hero_clk_en, out_ready,
    input  out_valid, out_wdat, out_sub, out_last, out_err, fifo_level,
           overflow_pulse, proto_err_pulse
  );
endinterface

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: frames beats into transactions and buffers them in a FIFO.
// Optional HERO_WRITE_RX_STATS_EN adds saturating completed/dropped transaction counters.
module hero_write_rx #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 36,
  parameter int SUB_W  = 7
) (
  input  logic clk,
  input  logic rst,
  hero_write_rx_if.slave bus
`ifdef HERO_WRITE_RX_STATS_EN
  ,
  output logic [15:0] xfer_done_cnt,
  output logic [15:0] xfer_drop_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [1:0] CT_VALID   = 2'd1;
  localparam logic [1:0] CT_DONE    = 2'd2;
  localparam logic [1:0] CT_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DROP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] wdat;
    logic [SUB_W-1:0]  sub;
    logic              last;
    logic              err;
  } entry_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              proto_q, proto_d;
  entry_t            mem_q [DEPTH];
  entry_t            push_entry, head;
  logic              push_en, pop_en, beat, is_done, has_space;

  // The space check reserves the last slot so an abort marker always fits.
  always_comb begin
    beat       = bus.hero_clk_en && (bus.hero_cycle_type == CT_VALID ||
                                     bus.hero_cycle_type == CT_DONE);
    is_done    = (bus.hero_cycle_type == CT_DONE);
    has_space  = level_q < LVL_W'(DEPTH - 1);
    pop_en     = (level_q != '0) && bus.out_ready;
    proto_d    = bus.hero_clk_en && (bus.hero_cycle_type == CT_ILLEGAL);
    state_d    = state_q;
    push_en    = 1'b0;
    ovf_d      = 1'b0;
    push_entry.wdat = bus.hero_wdat;
    push_entry.sub  = bus.hero_sub;
    push_entry.last = is_done;
    push_entry.err  = 1'b0;
    if (beat) begin
      case (state_q)
        ST_IDLE: begin
          if (has_space) begin
            push_en = 1'b1;
            state_d = is_done ? ST_IDLE : ST_XFER;
          end else begin
            ovf_d   = 1'b1;
            state_d = is_done ? ST_IDLE : ST_DROP;
          end
        end
        ST_XFER: begin
          if (has_space) begin
            push_en = 1'b1;
            state_d = is_done ? ST_IDLE : ST_XFER;
          end else begin
            // An overflowing DONE already ends the transaction, so nothing is left to drop.
            push_en         = 1'b1;
            push_entry.wdat = '0;
            push_entry.sub  = '0;
            push_entry.last = 1'b1;
            push_entry.err  = 1'b1;
            ovf_d           = 1'b1;
            state_d         = is_done ? ST_IDLE : ST_DROP;
          end
        end
        ST_DROP: begin
          if (is_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    level_d = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      proto_q  <= proto_d;
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_entry;
  end

  // Head fields read as zero whenever the FIFO is empty.
  assign head                = mem_q[rd_ptr_q];
  assign bus.out_valid       = (level_q != '0);
  assign bus.out_wdat        = bus.out_valid ? head.wdat : '0;
  assign bus.out_sub         = bus.out_valid ? head.sub  : '0;
  assign bus.out_last        = bus.out_valid & head.last;
  assign bus.out_err         = bus.out_valid & head.err;
  assign bus.fifo_level      = level_q;
  assign bus.overflow_pulse  = ovf_q;
  assign bus.proto_err_pulse = proto_q;

`ifdef HERO_WRITE_RX_STATS_EN
  logic [15:0] done_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_en && push_entry.last && !push_entry.err && done_cnt_q != 16'hFFFF)
        done_cnt_q <= done_cnt_q + 16'd1;
      if (ovf_d && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign xfer_done_cnt = done_cnt_q;
  assign xfer_drop_cnt = drop_cnt_q;
`endif
endmodule
